sms_timing_ring: RTL and testbench
==================================

SMS_TIMING_RING -- requirements
Module: sms_timing_ring

Interface
REQ-001 Parameter RING_LEN, default 10: number of timing positions T1..TRING_LEN per memory cycle.
REQ-002 Parameter CNT_W, default 8: width of the completed-cycle counter.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_n  input  1  start request, active-low; 1 or z is inactive (pull-up semantics).
REQ-006 stop_n  input  1  stop request, active-low; 1 or z is inactive.
REQ-007 hold_n  input  1  freeze ring, active-low; 1 or z is inactive.
REQ-008 single_n  input  1  single-cycle mode, active-low; 1 or z is inactive.
REQ-009 t  output  RING_LEN  one-hot timing gates; bit 0 is T1.
REQ-010 running  output  1  high while in RUN.
REQ-011 cycle_end  output  1  high while T(RING_LEN) is active.
REQ-012 cycles  output  CNT_W  count of completed cycles.
REQ-013 busy_oc  output  1  open collector: drives 1 while running, otherwise z.

Function
REQ-014 Input conditioning: each active-low input SHALL be treated as 1 when its value is 1 or z and as 0 otherwise, then passed through a 2-flop synchronizer.
REQ-015 States: IDLE (t all zero) and RUN (exactly one bit of t set).
REQ-016 IDLE->RUN: synchronized start low in IDLE; T1 is asserted after the 3rd rising edge following start_n going low.
REQ-017 Start while in RUN is ignored.
REQ-018 In RUN, with hold inactive, t advances one position per clock, T1 through T(RING_LEN).
REQ-019 Hold active: t, cycles and the stop latch freeze; a synchronized stop asserted during hold is still latched.
REQ-020 Stop latch: set by synchronized stop low in RUN; cleared on entry to IDLE.
REQ-021 At T(RING_LEN) with hold inactive, the next state is IDLE if the stop latch is set, stop is currently low, or single is low; otherwise it is T1.
REQ-022 Start and stop synchronized in the same cycle in IDLE: enter RUN with the stop latch set, giving exactly one cycle.
REQ-023 cycles increments by 1 on each T(RING_LEN)->next transition and wraps from 2^CNT_W-1 to 0.
REQ-024 The ring is never partially full or empty in RUN; any non-one-hot value of t forces IDLE on the next clock without incrementing cycles.
REQ-025 All outputs are registered or decoded directly from registers; no combinational path from any input to any output.

Reset
REQ-026 reset high: immediately (asynchronously) t=0, running=0, cycle_end=0, cycles=0, busy_oc=z, stop latch=0, synchronizers=1.
REQ-027 Reset mid-cycle abandons the cycle with no count; after release the block waits in IDLE for a new start.

Structure
REQ-028 Shared package sms_pkg: ipu pull-up function, RING_LEN default, state enum {IDLE, RUN}.
REQ-029 One sub-module, sms_input_sync: ipu conditioning plus 2-flop synchronizer, instantiated once per input.

Verification
REQ-030 Continuous run: start_n=0 for 1 clk, stop idle -> T1 after 3 edges, then T1..T10, T1 ...; cycles=1 on the first T10->T1 transition.
REQ-031 Stop mid-cycle: stop_n low at T4 -> ring completes T10 -> IDLE; cycles +1; running=0; busy_oc=z.
REQ-032 Single mode: single_n=0, pulse start -> exactly one T1..T10 sweep, cycles 0->1, then IDLE.
REQ-033 Hold: hold_n=0 at T6 for 5 clks -> T6 held 5 clks, then T7; cycles unchanged during hold.
REQ-034 Wrap and reset: preload 255 cycles, complete one more -> cycles=0; assert reset at T3 -> t=0 at once, cycles=0, IDLE after release.
REQ-035 Z inputs: all inputs z after reset -> block remains IDLE indefinitely, t=0.

Source files
------------

// File: rtl/sms_pkg.sv
// sms_pkg: shared types, defaults and input conditioning for the SMS timing ring.
package sms_pkg;
  localparam int RING_LEN_DEF = 10;
  typedef enum logic {IDLE, RUN} state_t;
  // Pull-up view of an active-low pin: floating reads as inactive, anything unknown as asserted.
  function automatic logic ipu(input logic v);
    return (v === 1'b1) || (v === 1'bz);
  endfunction
endpackage

// File: rtl/sms_input_sync.sv
// sms_input_sync: pull-up conditioning plus 2-flop synchronizer for one active-low input.
module sms_input_sync
  import sms_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_n,
  output logic q_n
);
  logic meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q_n, meta} <= 2'b11;
    else {q_n, meta} <= {meta, ipu(d_n)};
endmodule

// File: rtl/sms_timing_ring.sv
// sms_timing_ring: one-hot memory timing ring T1..TRING_LEN with start/stop/hold/single control.
module sms_timing_ring
  import sms_pkg::*;
#(
  parameter int RING_LEN = RING_LEN_DEF,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_n,
  input  logic                stop_n,
  input  logic                hold_n,
  input  logic                single_n,
  output logic [RING_LEN-1:0] t,
  output logic                running,
  output logic                cycle_end,
  output logic [CNT_W-1:0]    cycles,
  output logic                busy_oc
);
  localparam logic [RING_LEN-1:0] T1 = RING_LEN'(1);
  state_t state;
  logic start_s, stop_s, hold_s, single_s, stop_lat, onehot;
  sms_input_sync u_start  (.clk(clk), .reset(reset), .d_n(start_n),  .q_n(start_s));
  sms_input_sync u_stop   (.clk(clk), .reset(reset), .d_n(stop_n),   .q_n(stop_s));
  sms_input_sync u_hold   (.clk(clk), .reset(reset), .d_n(hold_n),   .q_n(hold_s));
  sms_input_sync u_single (.clk(clk), .reset(reset), .d_n(single_n), .q_n(single_s));
  assign onehot = (t != '0) && ((t & (t - T1)) == '0);
  // A corrupted ring abandons the cycle uncounted rather than trying to recover mid-sweep.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      t        <= '0;
      stop_lat <= 1'b0;
      cycles   <= '0;
    end else if (state == IDLE) begin
      t        <= start_s ? '0 : T1;
      state    <= start_s ? IDLE : RUN;
      stop_lat <= !start_s && !stop_s;
    end else if (!onehot) begin
      state    <= IDLE;
      t        <= '0;
      stop_lat <= 1'b0;
    end else if (!hold_s) begin
      stop_lat <= stop_lat || !stop_s;
    end else if (t[RING_LEN-1]) begin
      cycles <= cycles + CNT_W'(1);
      if (stop_lat || !stop_s || !single_s) begin
        state    <= IDLE;
        t        <= '0;
        stop_lat <= 1'b0;
      end else t <= T1;
    end else begin
      t        <= t << 1;
      stop_lat <= stop_lat || !stop_s;
    end
  assign running   = (state == RUN);
  assign cycle_end = t[RING_LEN-1];
  assign busy_oc   = running ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_sms_timing_ring.sv
// tb_sms_timing_ring: directed checks of the SMS timing ring with hand-computed expectations.
module tb_sms_timing_ring;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic oe = 1'b1;
  logic start_v = 1'b1, stop_v = 1'b1, hold_v = 1'b1, single_v = 1'b1;
  wire start_n, stop_n, hold_n, single_n, busy_oc;
  logic [9:0] t;
  logic running, cycle_end;
  logic [7:0] cycles;
  int n_checks = 0, n_errors = 0;
  assign start_n  = oe ? start_v  : 1'bz;
  assign stop_n   = oe ? stop_v   : 1'bz;
  assign hold_n   = oe ? hold_v   : 1'bz;
  assign single_n = oe ? single_v : 1'bz;
  pullup (start_n);
  pullup (stop_n);
  pullup (hold_n);
  pullup (single_n);
  pulldown (busy_oc);
  sms_timing_ring #(.RING_LEN(10), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .stop_n(stop_n), .hold_n(hold_n),
    .single_n(single_n), .t(t), .running(running), .cycle_end(cycle_end),
    .cycles(cycles), .busy_oc(busy_oc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag, input logic [31:0] cyc);
    check({tag, "_t"}, 32'(t), 32'h0);
    check({tag, "_run"}, 32'(running), 32'h0);
    check({tag, "_busy"}, 32'(busy_oc), 32'h0);
    check({tag, "_cyc"}, 32'(cycles), cyc);
  endtask
  initial begin
    #2 reset = 1'b1;
    #1 idle_chk("rst", 0);
    check("rst_end", 32'(cycle_end), 32'h0);
    step(2);
    reset = 1'b0;
    step(3);
    idle_chk("post_rst", 0);
    // continuous run
    start_v = 1'b0;
    step(1);
    start_v = 1'b1;
    step(2);
    check("cont_t1", 32'(t), 32'h1);
    check("cont_run", 32'(running), 32'h1);
    check("cont_busy", 32'(busy_oc), 32'h1);
    for (int k = 1; k < 10; k++) begin
      step(1);
      check("cont_adv", 32'(t), 32'h1 << k);
    end
    check("cont_end", 32'(cycle_end), 32'h1);
    check("cont_cyc0", 32'(cycles), 32'h0);
    step(1);
    check("cont_wrap_t", 32'(t), 32'h1);
    check("cont_cyc1", 32'(cycles), 32'h1);
    step(10);
    check("cont_cyc2", 32'(cycles), 32'h2);
    // stop requested at T4
    step(3);
    check("stop_t4", 32'(t), 32'h8);
    stop_v = 1'b0;
    step(1);
    stop_v = 1'b1;
    step(5);
    check("stop_t10", 32'(t), 32'h200);
    check("stop_run", 32'(running), 32'h1);
    step(1);
    idle_chk("stop_idle", 3);
    step(5);
    idle_chk("stop_stay", 3);
    // single mode
    single_v = 1'b0;
    start_v = 1'b0;
    step(1);
    start_v = 1'b1;
    step(2);
    check("sgl_t1", 32'(t), 32'h1);
    step(9);
    check("sgl_t10", 32'(t), 32'h200);
    step(1);
    idle_chk("sgl_idle", 4);
    step(3);
    idle_chk("sgl_stay", 4);
    single_v = 1'b1;
    step(3);
    // hold low for 5 clocks, launched so the freeze lands on T6
    start_v = 1'b0;
    step(1);
    start_v = 1'b1;
    step(5);
    check("hold_t4", 32'(t), 32'h8);
    hold_v = 1'b0;
    step(2);
    check("hold_t6", 32'(t), 32'h20);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("hold_frz", 32'(t), 32'h20);
    end
    hold_v = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      check("hold_frz2", 32'(t), 32'h20);
    end
    check("hold_cyc", 32'(cycles), 32'h4);
    step(1);
    check("hold_t7", 32'(t), 32'h40);
    // run up to 255 completed cycles, then wrap
    step(4);
    check("wrap_c5", 32'(cycles), 32'h5);
    step(2500);
    check("wrap_c255", 32'(cycles), 32'hff);
    check("wrap_t1", 32'(t), 32'h1);
    step(10);
    check("wrap_c0", 32'(cycles), 32'h0);
    step(2);
    check("wrap_t3", 32'(t), 32'h4);
    reset = 1'b1;
    #1 idle_chk("arst", 0);
    step(2);
    reset = 1'b0;
    step(5);
    idle_chk("arst_rel", 0);
    // start and stop together: exactly one sweep
    start_v = 1'b0;
    stop_v = 1'b0;
    step(1);
    start_v = 1'b1;
    stop_v = 1'b1;
    step(2);
    check("ss_t1", 32'(t), 32'h1);
    step(9);
    check("ss_t10", 32'(t), 32'h200);
    step(1);
    idle_chk("ss_idle", 1);
    // all inputs floating
    oe = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(5);
      idle_chk("zin", 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
